lfsr_misr_rx: RTL and testbench

//  Receiving end of the PRPG pattern stream: a multiple-input signature register (MISR) that compacts
//  8-bit patterns produced by the LFSR pattern generator into a signature and compares it to a golden

---
 rtl/lfsr_misr_rx.sv | 139 +++++++++++++
 tb/tb_lfsr_misr_rx.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_misr_rx.sv
// Multiple-input signature register: compacts 8-bit pattern beats into a signature and
// compares it against a golden value, driven by the 14-bit PRPG instruction word format.
module lfsr_misr_rx #(
  parameter int unsigned W    = 8,
  parameter int unsigned OP_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ctl_valid,
  output logic               ctl_ready,
  input  logic [OP_W+W-1:0]  ctl_word,
  input  logic               din_valid,
  output logic               din_ready,
  input  logic [0:W-1]       din,
  output logic [0:W-1]       sig,
  output logic               busy,
  output logic               chk_valid,
  output logic               pass,
  output logic               err_op,
  output logic               halted
);

  typedef enum logic [1:0] {StIdle, StCompact, StHalt} state_e;

  localparam logic [OP_W-1:0] OpCfgTap  = OP_W'(6'b000001);
  localparam logic [OP_W-1:0] OpInitSig = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OpRun     = OP_W'(6'b000011);
  localparam logic [OP_W-1:0] OpSetGold = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OpCheck   = OP_W'(6'b001001);
  localparam logic [OP_W-1:0] OpHalt    = OP_W'(6'b111111);

  state_e         state_q, state_d;
  logic [0:W-1]   sig_q, sig_d;
  logic [W-2:0]   tap_q, tap_d;
  logic [0:W-1]   golden_q, golden_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic           pass_q, pass_d;
  logic           chk_q, chk_d;
  logic           err_q, err_d;
  logic [0:W-1]   misr;

  logic [OP_W-1:0] opcode;
  logic [W-1:0]    arg;
  logic            shamt;
  logic [W-2:0]    funct;

  assign opcode = ctl_word[OP_W+W-1:W];
  assign arg    = ctl_word[W-1:0];
  assign shamt  = ctl_word[W-1];
  assign funct  = ctl_word[W-2:0];

  // With din=0 this is exactly the generator's run step, so a shared seed/tap tracks it.
  always_comb begin
    misr    = '0;
    misr[0] = sig_q[W-1] ^ din[0];
    for (int i = 1; i < W; i++) begin
      misr[i] = sig_q[i-1] ^ (tap_q[W-1-i] & sig_q[W-1]) ^ din[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    sig_d    = sig_q;
    tap_d    = tap_q;
    golden_d = golden_q;
    cnt_d    = cnt_q;
    pass_d   = pass_q;
    chk_d    = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ctl_valid) begin
          case (opcode)
            OpCfgTap: begin
              if (shamt) err_d = 1'b1;
              else       tap_d = funct;
            end
            OpInitSig: sig_d = arg;
            OpRun: begin
              if (arg != '0) begin
                cnt_d   = arg;
                state_d = StCompact;
              end
            end
            OpSetGold: golden_d = arg;
            OpCheck: begin
              pass_d = (sig_q == golden_q);
              chk_d  = 1'b1;
            end
            OpHalt:  state_d = StHalt;
            default: err_d = 1'b1;
          endcase
        end
      end
      StCompact: begin
        if (din_valid) begin
          sig_d = misr;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == W'(1)) state_d = StIdle;
        end
      end
      StHalt: ;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sig_q    <= '0;
      tap_q    <= '0;
      golden_q <= '0;
      cnt_q    <= '0;
      pass_q   <= 1'b0;
      chk_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sig_q    <= sig_d;
      tap_q    <= tap_d;
      golden_q <= golden_d;
      cnt_q    <= cnt_d;
      pass_q   <= pass_d;
      chk_q    <= chk_d;
      err_q    <= err_d;
    end
  end

  // Gated with rst_n so every output reads 0 while reset is held.
  assign ctl_ready = (state_q == StIdle) & rst_n;
  assign din_ready = (state_q == StCompact);
  assign busy      = (state_q == StCompact);
  assign halted    = (state_q == StHalt);
  assign sig       = sig_q;
  assign chk_valid = chk_q;
  assign pass      = pass_q;
  assign err_op    = err_q;

endmodule

// File: tb/tb_lfsr_misr_rx.sv
// Self-checking bench for lfsr_misr_rx: table-driven single-beat vectors, a beat scoreboard
// and hand-written sequences for reset, check, stalled runs, illegal ops and halt.
module tb_lfsr_misr_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ctl_valid = 1'b0;
  logic        ctl_ready;
  logic [13:0] ctl_word = '0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [0:7]  din = '0;
  logic [0:7]  sig;
  logic        busy, chk_valid, pass, err_op, halted;

  lfsr_misr_rx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ctl_valid (ctl_valid),
    .ctl_ready (ctl_ready),
    .ctl_word  (ctl_word),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .din       (din),
    .sig       (sig),
    .busy      (busy),
    .chk_valid (chk_valid),
    .pass      (pass),
    .err_op    (err_op),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] OpCfgTap  = 6'b000001;
  localparam logic [5:0] OpInitSig = 6'b000010;
  localparam logic [5:0] OpRun     = 6'b000011;
  localparam logic [5:0] OpSetGold = 6'b001000;
  localparam logic [5:0] OpCheck   = 6'b001001;

  typedef struct {
    logic [6:0] tap;
    logic [0:7] seed;
    logic [0:7] d;
    logic [0:7] exp;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [0:7]  sb_q[$];
  logic [0:7]  exp_sig;
  logic [6:0]  exp_tap;
  vec_t        vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference step: shift toward bit 7, feedback mask {1, tap[6:0]} applied when bit 7 is set.
  function automatic logic [0:7] model(input logic [0:7] s, input logic [6:0] t,
                                       input logic [0:7] d);
    logic [0:7] m;
    m = {1'b1, t};
    return ({1'b0, s[0:6]} ^ (s[7] ? m : 8'h00)) ^ d;
  endfunction

  // All tasks start and end just after a falling edge.
  task automatic send_ctl(input logic [13:0] w);
    int t;
    t = 0;
    ctl_valid = 1'b1;
    ctl_word  = w;
    while (!ctl_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!ctl_ready) chk("ctl_accept_timeout", ctl_ready, 1);
    else @(posedge clk);
    @(negedge clk);
    ctl_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [0:7] d);
    int t;
    t = 0;
    din_valid = 1'b1;
    din       = d;
    while (!din_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!din_ready) begin
      chk("din_accept_timeout", din_ready, 1);
      @(negedge clk);
      din_valid = 1'b0;
    end else begin
      exp_sig = model(exp_sig, exp_tap, d);
      sb_q.push_back(exp_sig);
      @(posedge clk);
      @(negedge clk);
      din_valid = 1'b0;
      chk("sb_sig", sig, sb_q.pop_front());
    end
  endtask

  task automatic do_reset();
    ctl_valid = 1'b0;
    din_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    exp_sig = '0;
    exp_tap = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         beats;
    logic       tog;
    logic [0:7] frozen;

    vecs[0] = '{7'b0100101, 8'b11110000, 8'b00000000, 8'b01111000};
    vecs[1] = '{7'b0100101, 8'b11110000, 8'b11111111, 8'b10000111};
    vecs[2] = '{7'b0100101, 8'b00000001, 8'b00000000, 8'b10100101};
    vecs[3] = '{7'b0000000, 8'b10000000, 8'b00000000, 8'b01000000};
    vecs[4] = '{7'b1111111, 8'b00000001, 8'b00000000, 8'b11111111};
    vecs[5] = '{7'b1111111, 8'b00000001, 8'b11111111, 8'b00000000};
    vecs[6] = '{7'b0100101, 8'b00000001, 8'b10100101, 8'b00000000};
    exp_sig = '0;
    exp_tap = '0;

    // Outputs while reset is held.
    #2;
    chk("rst_sig", sig, 0);
    chk("rst_busy", busy, 0);
    chk("rst_chk_valid", chk_valid, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err_op", err_op, 0);
    chk("rst_halted", halted, 0);
    chk("rst_ctl_ready", ctl_ready, 0);
    chk("rst_din_ready", din_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ctl_ready", ctl_ready, 1);
    chk("idle_din_ready", din_ready, 0);

    foreach (vecs[k]) begin
      send_ctl({OpCfgTap, 1'b0, vecs[k].tap});
      exp_tap = vecs[k].tap;
      send_ctl({OpInitSig, vecs[k].seed});
      chk("vec_seed", sig, vecs[k].seed);
      exp_sig = vecs[k].seed;
      send_ctl({OpRun, 8'd1});
      chk("vec_busy", busy, 1);
      chk("vec_din_ready", din_ready, 1);
      send_beat(vecs[k].d);
      chk("vec_sig", sig, vecs[k].exp);
      chk("vec_done_busy", busy, 0);
      chk("vec_done_ctl_ready", ctl_ready, 1);
    end

    // run with arg 0 is a silent no-op.
    send_ctl({OpRun, 8'd0});
    chk("run0_busy", busy, 0);
    chk("run0_err_op", err_op, 0);

    // Check against golden: the last vector left the tap at 0100101.
    send_ctl({OpInitSig, 8'b00000001});
    exp_sig = 8'b00000001;
    send_ctl({OpRun, 8'd1});
    send_beat(8'h00);
    send_ctl({OpSetGold, 8'b10100101});
    chk("gold_no_chk_valid", chk_valid, 0);
    send_ctl({OpCheck, 8'h00});
    chk("chk1_valid", chk_valid, 1);
    chk("chk1_pass", pass, 1);
    @(negedge clk);
    chk("chk1_valid_drop", chk_valid, 0);
    chk("chk1_pass_hold", pass, 1);
    send_ctl({OpSetGold, 8'b10100100});
    send_ctl({OpCheck, 8'h00});
    chk("chk2_valid", chk_valid, 1);
    chk("chk2_pass", pass, 0);

    // Stalled run of 4 with an instruction held pending throughout.
    send_ctl({OpInitSig, 8'h3C});
    exp_sig = 8'h3C;
    send_ctl({OpRun, 8'd4});
    chk("t5_busy_start", busy, 1);
    ctl_valid = 1'b1;
    ctl_word  = {OpInitSig, 8'h5A};
    beats = 0;
    tog   = 1'b1;
    for (int c = 0; c < 40 && beats < 4; c++) begin
      din_valid = tog;
      din       = 8'($urandom);
      chk("t5_ctl_blocked", ctl_ready, 0);
      chk("t5_busy", busy, 1);
      if (din_valid && din_ready) begin
        exp_sig = model(exp_sig, exp_tap, din);
        beats++;
      end
      @(posedge clk);
      @(negedge clk);
      chk("t5_sig", sig, exp_sig);
      tog = ~tog;
    end
    din_valid = 1'b0;
    chk("t5_beats", beats, 4);
    chk("t5_busy_end", busy, 0);
    chk("t5_ctl_ready", ctl_ready, 1);
    @(posedge clk);
    @(negedge clk);
    ctl_valid = 1'b0;
    chk("t5_pending_init", sig, 8'h5A);
    exp_sig = 8'h5A;

    // Illegal config_tap and unknown opcode; tap must survive.
    send_ctl({OpCfgTap, 1'b1, 7'b1111111});
    chk("err_cfg_pulse", err_op, 1);
    @(negedge clk);
    chk("err_cfg_drop", err_op, 0);
    send_ctl({6'b010101, 8'hFF});
    chk("err_unk_pulse", err_op, 1);
    chk("err_unk_sig", sig, 8'h5A);
    @(negedge clk);
    chk("err_unk_drop", err_op, 0);
    send_ctl({OpInitSig, 8'b00000001});
    exp_sig = 8'b00000001;
    send_ctl({OpRun, 8'd1});
    send_beat(8'h00);
    chk("tap_unchanged", sig, 8'b10100101);

    // Halt freezes everything until reset.
    frozen = sig;
    send_ctl(14'h3FFF);
    chk("halt_halted", halted, 1);
    chk("halt_ctl_ready", ctl_ready, 0);
    chk("halt_din_ready", din_ready, 0);
    chk("halt_busy", busy, 0);
    ctl_valid = 1'b1;
    ctl_word  = {OpInitSig, 8'h00};
    din_valid = 1'b1;
    din       = 8'hFF;
    repeat (5) begin
      @(negedge clk);
      chk("halt_sig_frozen", sig, frozen);
      chk("halt_sticky", halted, 1);
    end
    do_reset();
    chk("post_halt_halted", halted, 0);
    chk("post_halt_sig", sig, 0);
    chk("post_halt_ctl_ready", ctl_ready, 1);

    // Reset in the middle of a run.
    send_ctl({OpCfgTap, 1'b0, 7'b0100101});
    exp_tap = 7'b0100101;
    send_ctl({OpInitSig, 8'hC3});
    exp_sig = 8'hC3;
    send_ctl({OpRun, 8'd10});
    send_beat(8'h11);
    send_beat(8'h22);
    send_beat(8'h33);
    chk("t1_busy_mid", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t1_rst_sig", sig, 0);
    chk("t1_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t1_ctl_ready", ctl_ready, 1);
    chk("t1_din_ready", din_ready, 0);
    @(negedge clk);
    // Reset also cleared tap: a one-beat run from seed 00000001 only shifts.
    exp_tap = '0;
    send_ctl({OpInitSig, 8'b00000001});
    exp_sig = 8'b00000001;
    send_ctl({OpRun, 8'd1});
    send_beat(8'h00);
    chk("t1_tap_cleared", sig, 8'b10000000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
